edge_event_scheduler: RTL
=========================

// Module: edge_event_scheduler
// PURPOSE
//  Multi-channel edge-event controller. Per channel: synchronises a raw input, detects
//  edges and filters them by a per-channel edge select. Queues one event per channel and
//  arbitrates events round-robin onto a single valid/ready event stream.
//  Sits between asynchronous pins/flags and the consumer that services edge events.
// PARAMETERS
//  N_CH       4      number of input channels (2..16)
//  CFG_RST    2'b11  reset edge select of every channel (see cfg_sel encoding)
//  ARM_CYCLES 3      cycles after reset release during which detected edges are discarded
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  a_in       in   N_CH           raw asynchronous channel inputs
//  cfg_we     in   1              write edge select of channel cfg_ch
//  cfg_ch     in   $clog2(N_CH)   channel index for cfg write
//  cfg_sel    in   2              00 off, 01 rise, 10 fall, 11 both
//  evt_valid  out  1              event available
//  evt_ready  in   1              consumer accepts event (handshake when valid&ready)
//  evt_ch     out  $clog2(N_CH)   channel of current event
//  evt_rise   out  1              1 = rising edge, 0 = falling edge
//  ovf        out  N_CH           sticky per-channel overflow (event dropped)
//  ovf_clr    in   1              clears all ovf bits (synchronous)
// BEHAVIOUR
//  Reset: all flops 0 except cfg regs = CFG_RST; outputs evt_valid=0, evt_ch=0,
//   evt_rise=0, ovf=0. Arm counter loads 0.
//  Sync/detect per channel: s1<=a_in, s2<=s1, prv<=s2; rise=s2&~prv, fall=~s2&prv.
//   a_in changing before edge k -> rise/fall true between edges k+1 and k+2.
//  Arm: counter increments each cycle to ARM_CYCLES then holds; edges while
//   count<ARM_CYCLES are discarded (no slot load, no ovf). Covers inputs high at reset.
//  Filter: an edge is accepted only if its type is enabled in cfg_sel of that channel.
//   cfg write takes effect for edges detected on the following cycle; a pending slot
//   is never cleared by a cfg change.
//  Slot per channel: {pend, rise}. Accepted edge loads slot at the next clk edge, so
//   evt_valid can rise at the earliest at edge k+3 after input change at edge k.
//   Accepted edge while pend=1 and slot not drained this cycle -> edge dropped,
//   ovf[ch]<=1. Slot drained and new edge same cycle -> slot reloads, no ovf.
//  Output register: loads when (!evt_valid | evt_ready) and any pend=1; selected slot
//   cleared in same cycle. Back-to-back events: one accept per cycle, no bubble.
//  While evt_valid & !evt_ready: evt_ch, evt_rise held stable; evt_valid never drops
//   without handshake.
//  Arbiter: round-robin; pointer = last granted ch; search starts at ptr+1, wraps at
//   N_CH-1 -> 0. After reset ptr = N_CH-1 (ch0 has first priority).
//  ovf: ovf_clr and new overflow same cycle -> ovf bit ends 1 (set wins).
//  Reset asserted mid-operation: all slots, output event and ovf lost immediately; cfg
//   returns to CFG_RST; arm window restarts.
// STRUCTURE
//  Package edge_sched_pkg: cfg_sel encoding constants (SEL_OFF/RISE/FALL/BOTH),
//   chan index width function.
//  Sub-module edge_sched_chan: sync chain, detect, filter, slot, ovf for one channel;
//   generate N_CH instances. Top holds cfg regs, arm counter, RR arbiter, output reg.
// TESTING
//  1 Reset with a_in[0]=1 held, release -> no event, evt_valid stays 0 for 20 cycles.
//  2 cfg ch1=01, a_in[1] 0->1 at edge 10, evt_ready=1 -> evt_valid=1 at edge 13,
//    evt_ch=1, evt_rise=1; 1->0 later -> no event.
//  3 a_in[0..3] rise same cycle, evt_ready=1 -> events ch0,ch1,ch2,ch3 on 4 consecutive
//    cycles; repeat -> order continues ch0.. (ptr wrap).
//  4 evt_ready=0, ch2 rises then falls (sel=11) -> first event held stable, second in
//    slot; third edge -> ovf[2]=1; ovf_clr -> ovf[2]=0.
//  5 Slot drain and new edge same cycle on ch0 -> no ovf, next event ch0 fall.
//  6 rst_n low mid-stream with evt_valid=1 -> evt_valid=0 asynchronously, ovf=0,
//    cfg readback via behaviour = CFG_RST.

Source files
------------

// File: rtl/edge_sched_pkg.sv
// Shared definitions for the edge event scheduler.
//   SEL_*   : per-channel edge select encoding (off / rise / fall / both)
//   chan_w  : width of a channel index for a given channel count (minimum 1)
package edge_sched_pkg;

   localparam logic [1:0] SEL_OFF  = 2'b00;
   localparam logic [1:0] SEL_RISE = 2'b01;
   localparam logic [1:0] SEL_FALL = 2'b10;
   localparam logic [1:0] SEL_BOTH = 2'b11;

   function automatic int chan_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/edge_sched_chan.sv
// One channel of the edge event scheduler: two-flop synchroniser, edge detect,
// edge-select filter, single-entry event slot and sticky overflow flag.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   a_i         : raw asynchronous input
//   armed_i     : edges are only accepted once the arm window has elapsed
//   sel_i       : edge select (SEL_OFF/RISE/FALL/BOTH)
//   drain_i     : arbiter takes the slot this cycle
//   ovf_clr_i   : synchronous clear of the overflow flag
//   pend_o      : slot holds an event
//   rise_o      : slot event type (1 rise, 0 fall)
//   ovf_o       : sticky overflow, an accepted edge found the slot full
module edge_sched_chan
   import edge_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a_i,
   input  logic       armed_i,
   input  logic [1:0] sel_i,
   input  logic       drain_i,
   input  logic       ovf_clr_i,
   output logic       pend_o,
   output logic       rise_o,
   output logic       ovf_o
);

   logic s1_q;
   logic s2_q;
   logic prv_q;
   logic pend_q;
   logic rise_q;
   logic ovf_q;

   logic rise_det;
   logic fall_det;
   logic en_rise;
   logic en_fall;
   logic accept;
   logic drop;

   assign rise_det = s2_q & ~prv_q;
   assign fall_det = ~s2_q & prv_q;

   assign en_rise = (sel_i == SEL_RISE) || (sel_i == SEL_BOTH);
   assign en_fall = (sel_i == SEL_FALL) || (sel_i == SEL_BOTH);

   assign accept = armed_i & ((rise_det & en_rise) | (fall_det & en_fall));
   // A slot being drained this cycle can take the new edge without loss.
   assign drop   = accept & pend_q & ~drain_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prv_q  <= 1'b0;
         pend_q <= 1'b0;
         rise_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s1_q  <= a_i;
         s2_q  <= s1_q;
         prv_q <= s2_q;
         if (accept && !drop) begin
            pend_q <= 1'b1;
            rise_q <= rise_det;
         end else if (drain_i) begin
            pend_q <= 1'b0;
         end
         // New overflow wins over a simultaneous clear.
         ovf_q <= drop | (ovf_q & ~ovf_clr_i);
      end
   end

   assign pend_o = pend_q;
   assign rise_o = rise_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel edge event scheduler. Each channel synchronises its raw input,
// filters edges by its edge select and queues one event; a round-robin arbiter
// moves queued events into a registered valid/ready output stage.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   a_in[N_CH]          : raw asynchronous channel inputs
//   cfg_we/ch/sel       : write edge select of one channel
//   evt_valid/ready     : event stream handshake
//   evt_ch, evt_rise    : channel and edge type of the presented event
//   ovf[N_CH]           : sticky per-channel overflow
//   ovf_clr             : clears all overflow flags
module edge_event_scheduler
   import edge_sched_pkg::*;
#(
   parameter int         N_CH       = 4,
   parameter logic [1:0] CFG_RST    = SEL_BOTH,
   parameter int         ARM_CYCLES = 3,
   localparam int        CW         = chan_w(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] a_in,
   input  logic            cfg_we,
   input  logic [CW-1:0]   cfg_ch,
   input  logic [1:0]      cfg_sel,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [CW-1:0]   evt_ch,
   output logic            evt_rise,
   output logic [N_CH-1:0] ovf,
   input  logic            ovf_clr
);

   localparam int ACW = (ARM_CYCLES < 1) ? 1 : $clog2(ARM_CYCLES + 1);

   logic [1:0]      cfg_q [N_CH];
   logic [ACW-1:0]  arm_cnt_q;
   logic [ACW-1:0]  arm_cnt_d;
   logic            armed;

   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] slot_rise;
   logic [N_CH-1:0] drain;

   logic [CW-1:0]   ptr_q;
   logic [CW-1:0]   gnt_idx;
   logic            gnt_found;
   logic            load;

   logic            evt_valid_q;
   logic [CW-1:0]   evt_ch_q;
   logic            evt_rise_q;

   // ---------------- configuration registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            cfg_q[c] <= CFG_RST;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (cfg_we && (cfg_ch == CW'(c))) begin
               cfg_q[c] <= cfg_sel;
            end
         end
      end
   end

   // ---------------- arm window ----------------
   // Discards edges produced while the synchronisers fill after reset, so
   // inputs already high at reset do not look like rising edges.
   assign armed     = (arm_cnt_q == ACW'(ARM_CYCLES));
   assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ACW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_cnt_q <= '0;
      end else begin
         arm_cnt_q <= arm_cnt_d;
      end
   end

   // ---------------- channels ----------------
   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      edge_sched_chan u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .a_i       (a_in[g]),
         .armed_i   (armed),
         .sel_i     (cfg_q[g]),
         .drain_i   (drain[g]),
         .ovf_clr_i (ovf_clr),
         .pend_o    (pend[g]),
         .rise_o    (slot_rise[g]),
         .ovf_o     (ovf[g])
      );
   end

   // ---------------- round-robin arbiter ----------------
   // Search starts one past the last granted channel and wraps to channel 0.
   always_comb begin : arb
      int            j;
      logic [CW-1:0] idx;
      j         = 0;
      idx       = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 1; i <= N_CH; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N_CH) begin
            j = j - N_CH;
         end
         idx = CW'(j);
         if (!gnt_found && pend[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

   // Output stage refills in the same cycle it is emptied: no bubble.
   assign load  = (!evt_valid_q || evt_ready) && gnt_found;
   assign drain = load ? ({{(N_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;

   // ---------------- output register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         evt_rise_q  <= 1'b0;
         ptr_q       <= CW'(N_CH - 1);
      end else if (load) begin
         evt_valid_q <= 1'b1;
         evt_ch_q    <= gnt_idx;
         evt_rise_q  <= slot_rise[gnt_idx];
         ptr_q       <= gnt_idx;
      end else if (evt_ready) begin
         evt_valid_q <= 1'b0;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_ch    = evt_ch_q;
   assign evt_rise  = evt_rise_q;

endmodule
